// File: rtl/reg_bank_seq.sv
// reg_bank_seq: parametrised multi-port register file with a load/store-multiple
// sequencer.
//   clk, rst            : clock, synchronous active-high reset
//   rd_sel_a/b/c        : read indices; b/c outputs gated by gate_b/gate_c
//   a_data/b_data/c_data: combinational read data (optional same-cycle bypass)
//   wr_*                : primary write port (highest priority)
//   wb_*                : secondary write port
//   pc_inc              : PC += PC_STEP when no port writes PC
//   pc, sp              : registered views of R[PC_IDX], R[SP_IDX]
//   lsm_*               : sequencer control/handshake; walks lsm_list ascending
module reg_bank_seq #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned PC_IDX  = 15,
    parameter int unsigned SP_IDX  = 13,
    parameter int unsigned PC_STEP = 4,
    parameter int unsigned BYPASS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       rd_sel_a,
    input  logic [ADDR_W-1:0]       rd_sel_b,
    input  logic [ADDR_W-1:0]       rd_sel_c,
    input  logic                    gate_b,
    input  logic                    gate_c,
    output logic [DATA_W-1:0]       a_data,
    output logic [DATA_W-1:0]       b_data,
    output logic [DATA_W-1:0]       c_data,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wb_en,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic                    pc_inc,
    output logic [DATA_W-1:0]       pc,
    output logic [DATA_W-1:0]       sp,
    input  logic                    lsm_start,
    input  logic [(2**ADDR_W)-1:0]  lsm_list,
    input  logic                    lsm_abort,
    input  logic                    lsm_ready,
    output logic                    lsm_valid,
    output logic [ADDR_W-1:0]       lsm_reg,
    output logic                    lsm_busy,
    output logic                    lsm_done,
    output logic [ADDR_W:0]         lsm_count
);

    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_IDX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [DATA_W-1:0] regs [NREGS];

    state_t             state_q, state_d;
    logic [NREGS-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_d, busy_d, done_d;
    logic [ADDR_W-1:0]  reg_d;

    // Lowest set bit of a register list (ascending walk order).
    function automatic logic [ADDR_W-1:0] lowest_idx(input logic [NREGS-1:0] m);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int i = int'(NREGS) - 1; i >= 0; i--) begin
            if (m[i]) idx = ADDR_W'(i);
        end
        return idx;
    endfunction

    // Register array: wr beats wb beats pc_inc for the same index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (wr_en && wr_addr == ADDR_W'(i))
                    regs[i] <= wr_data;
                else if (wb_en && wb_addr == ADDR_W'(i))
                    regs[i] <= wb_data;
                else if (pc_inc && i == int'(PC_IDX))
                    regs[i] <= regs[i] + DATA_W'(PC_STEP);
            end
        end
    end

    assign pc = regs[PC_A];
    assign sp = regs[SP_A];

    // Read port A with optional same-cycle forwarding (wr before wb).
    always_comb begin
        a_data = regs[rd_sel_a];
        if (BYPASS != 0) begin
            if (wr_en && wr_addr == rd_sel_a)      a_data = wr_data;
            else if (wb_en && wb_addr == rd_sel_a) a_data = wb_data;
        end
    end

    // Read port B, forced to zero when not gated on.
    always_comb begin
        b_data = regs[rd_sel_b];
        if (BYPASS != 0) begin
            if (wr_en && wr_addr == rd_sel_b)      b_data = wr_data;
            else if (wb_en && wb_addr == rd_sel_b) b_data = wb_data;
        end
        if (!gate_b) b_data = '0;
    end

    // Read port C, forced to zero when not gated on.
    always_comb begin
        c_data = regs[rd_sel_c];
        if (BYPASS != 0) begin
            if (wr_en && wr_addr == rd_sel_c)      c_data = wr_data;
            else if (wb_en && wb_addr == rd_sel_c) c_data = wb_data;
        end
        if (!gate_c) c_data = '0;
    end

    // Sequencer state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            count_q   <= '0;
            lsm_valid <= 1'b0;
            lsm_busy  <= 1'b0;
            lsm_done  <= 1'b0;
            lsm_reg   <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
            lsm_valid <= valid_d;
            lsm_busy  <= busy_d;
            lsm_done  <= done_d;
            lsm_reg   <= reg_d;
        end
    end

    assign lsm_count = count_q;

    // Sequencer next state; outputs are decoded from the next state so they
    // line up with the state register.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (lsm_start) begin
                    count_d = '0;
                    if (lsm_list != '0) begin
                        mask_d  = lsm_list;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (lsm_abort) begin
                    mask_d  = '0;
                    state_d = IDLE;
                end else if (lsm_ready) begin
                    // x & (x-1) drops the lowest set bit.
                    mask_d  = mask_q & (mask_q - NREGS'(1));
                    count_d = count_q + CNT_W'(1);
                    if (mask_d == '0) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == RUN);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        reg_d   = valid_d ? lowest_idx(mask_d) : '0;
    end

endmodule

// File: tb/tb_reg_bank_seq.sv
// Directed bench for reg_bank_seq: two instances (bypass on/off) share inputs;
// a list/queue reference model is compared against outputs every negedge.
module tb_reg_bank_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rd_sel_a, rd_sel_b, rd_sel_c;
    logic        gate_b, gate_c;
    logic        wr_en, wb_en, pc_inc;
    logic [3:0]  wr_addr, wb_addr;
    logic [31:0] wr_data, wb_data;
    logic        lsm_start, lsm_abort, lsm_ready;
    logic [15:0] lsm_list;

    logic [31:0] a_data, b_data, c_data, pc, sp;
    logic        lsm_valid, lsm_busy, lsm_done;
    logic [3:0]  lsm_reg;
    logic [4:0]  lsm_count;

    logic [31:0] n_a, n_b, n_c, n_pc, n_sp;
    logic        n_valid, n_busy, n_done;
    logic [3:0]  n_reg;
    logic [4:0]  n_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bank_seq dut (
        .clk(clk), .rst(rst),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_sel_c(rd_sel_c),
        .gate_b(gate_b), .gate_c(gate_c),
        .a_data(a_data), .b_data(b_data), .c_data(c_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pc_inc(pc_inc), .pc(pc), .sp(sp),
        .lsm_start(lsm_start), .lsm_list(lsm_list), .lsm_abort(lsm_abort),
        .lsm_ready(lsm_ready), .lsm_valid(lsm_valid), .lsm_reg(lsm_reg),
        .lsm_busy(lsm_busy), .lsm_done(lsm_done), .lsm_count(lsm_count)
    );

    reg_bank_seq #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_sel_c(rd_sel_c),
        .gate_b(gate_b), .gate_c(gate_c),
        .a_data(n_a), .b_data(n_b), .c_data(n_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pc_inc(pc_inc), .pc(n_pc), .sp(n_sp),
        .lsm_start(lsm_start), .lsm_list(lsm_list), .lsm_abort(lsm_abort),
        .lsm_ready(lsm_ready), .lsm_valid(n_valid), .lsm_reg(n_reg),
        .lsm_busy(n_busy), .lsm_done(n_done), .lsm_count(n_count)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_r [16];
    int          m_q [$];      // registers still to be handed out, ascending
    int          m_mode;       // 0 idle, 1 walking list, 2 completion cycle
    int          m_count;
    bit          m_init = 1'b0;

    always @(posedge clk) begin
        logic [31:0] nxt [16];
        if (rst) begin
            foreach (m_r[i]) m_r[i] = 32'h0;
            m_q.delete();
            m_mode  = 0;
            m_count = 0;
            m_init  = 1'b1;
        end else begin
            // apply lowest priority first so higher priorities overwrite
            nxt = m_r;
            if (pc_inc) nxt[15] = m_r[15] + 32'd4;
            if (wb_en)  nxt[wb_addr] = wb_data;
            if (wr_en)  nxt[wr_addr] = wr_data;
            m_r = nxt;
            case (m_mode)
                0: if (lsm_start) begin
                       m_count = 0;
                       for (int i = 0; i < 16; i++) if (lsm_list[i]) m_q.push_back(i);
                       m_mode = (m_q.size() == 0) ? 2 : 1;
                   end
                1: if (lsm_abort) begin
                       m_q.delete();
                       m_mode = 0;
                   end else if (lsm_ready) begin
                       void'(m_q.pop_front());
                       m_count++;
                       if (m_q.size() == 0) m_mode = 2;
                   end
                default: m_mode = 0;
            endcase
        end
    end

    function automatic logic [31:0] exp_rd(input logic [3:0] s, input bit byp);
        if (byp && wr_en && wr_addr == s) return wr_data;
        if (byp && wb_en && wb_addr == s) return wb_data;
        return m_r[s];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (m_init) begin
            chk("a_data",    64'(a_data), 64'(exp_rd(rd_sel_a, 1'b1)));
            chk("b_data",    64'(b_data), 64'(gate_b ? exp_rd(rd_sel_b, 1'b1) : 32'h0));
            chk("c_data",    64'(c_data), 64'(gate_c ? exp_rd(rd_sel_c, 1'b1) : 32'h0));
            chk("nb_a_data", 64'(n_a),    64'(exp_rd(rd_sel_a, 1'b0)));
            chk("pc",        64'(pc),     64'(m_r[15]));
            chk("sp",        64'(sp),     64'(m_r[13]));
            chk("lsm_valid", 64'(lsm_valid), 64'(m_mode == 1));
            chk("lsm_busy",  64'(lsm_busy),  64'(m_mode != 0));
            chk("lsm_done",  64'(lsm_done),  64'(m_mode == 2));
            chk("lsm_reg",   64'(lsm_reg),   64'((m_mode == 1) ? m_q[0] : 0));
            chk("lsm_count", 64'(lsm_count), 64'(m_count));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_seq [5];
        logic       rpat [5];
        rst = 1'b1;
        rd_sel_a = 4'd0; rd_sel_b = 4'd0; rd_sel_c = 4'd0;
        gate_b = 1'b1; gate_c = 1'b1;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'h0;
        wb_en = 1'b0; wb_addr = 4'd0; wb_data = 32'h0;
        pc_inc = 1'b0;
        lsm_start = 1'b0; lsm_list = 16'h0; lsm_abort = 1'b0; lsm_ready = 1'b0;
        step(); step();
        rst = 1'b0;

        // reset state: all indices read 0
        @(negedge clk);
        chk("rst_pc", 64'(pc), 64'h0);
        chk("rst_sp", 64'(sp), 64'h0);
        chk("rst_busy", 64'(lsm_busy), 64'h0);
        chk("rst_count", 64'(lsm_count), 64'h0);
        for (int i = 0; i < 16; i++) begin
            rd_sel_a = 4'(i); rd_sel_b = 4'(15 - i); rd_sel_c = 4'(i);
            #1;
            chk("rst_rd_a", 64'(a_data), 64'h0);
            chk("rst_rd_b", 64'(b_data), 64'h0);
        end

        // same-cycle bypass vs next-cycle visibility
        step();
        rd_sel_a = 4'd3; rd_sel_b = 4'd3; gate_b = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("byp_a", 64'(a_data), 64'hDEADBEEF);
        chk("nobyp_a", 64'(n_a), 64'h0);
        chk("gate_b_off", 64'(b_data), 64'h0);
        step();
        wr_en = 1'b0; gate_b = 1'b1;
        @(negedge clk);
        chk("nobyp_a_next", 64'(n_a), 64'hDEADBEEF);

        // write priority and PC wrap
        step();
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'hFFFFFFFC;
        step();
        wr_addr = 4'd5; wr_data = 32'h11;
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h22;
        pc_inc = 1'b1; rd_sel_a = 4'd5; rd_sel_b = 4'd15; rd_sel_c = 4'd13;
        step();
        wr_en = 1'b0; wb_en = 1'b0; pc_inc = 1'b0;
        @(negedge clk);
        chk("prio_r5", 64'(a_data), 64'h11);
        chk("pc_wrap", 64'(pc), 64'h0);

        // wr to PC beats pc_inc; wb to SP
        step();
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h100;
        wb_en = 1'b1; wb_addr = 4'd13; wb_data = 32'h1000; pc_inc = 1'b1;
        step();
        wr_en = 1'b0; wb_en = 1'b0;
        step();
        pc_inc = 1'b0;
        @(negedge clk);
        chk("pc_over_inc", 64'(pc), 64'h104);
        chk("sp_wb", 64'(sp), 64'h1000);

        // list 0x8006, ready held high
        step();
        lsm_list = 16'h8006; lsm_ready = 1'b1; lsm_start = 1'b1;
        step();
        lsm_start = 1'b0;
        exp_seq = '{1, 2, 15, 0, 0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("seq_reg", 64'(lsm_reg), 64'(exp_seq[k]));
            step();
        end
        @(negedge clk);
        chk("seq_done", 64'(lsm_done), 64'h1);
        chk("seq_count", 64'(lsm_count), 64'd3);
        step();
        @(negedge clk);
        chk("seq_idle", 64'(lsm_busy), 64'h0);
        chk("seq_hold", 64'(lsm_count), 64'd3);

        // same list, ready 1,0,1,0,1
        lsm_start = 1'b1;
        step();
        lsm_start = 1'b0;
        rpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_seq = '{1, 2, 2, 15, 15};
        for (int k = 0; k < 5; k++) begin
            lsm_ready = rpat[k];
            @(negedge clk);
            chk("tog_reg", 64'(lsm_reg), 64'(exp_seq[k]));
            step();
        end
        @(negedge clk);
        chk("tog_done", 64'(lsm_done), 64'h1);
        chk("tog_count", 64'(lsm_count), 64'd3);
        step();

        // empty list completes at once
        lsm_list = 16'h0; lsm_start = 1'b1;
        step();
        lsm_start = 1'b0;
        @(negedge clk);
        chk("empty_done", 64'(lsm_done), 64'h1);
        chk("empty_valid", 64'(lsm_valid), 64'h0);
        chk("empty_count", 64'(lsm_count), 64'h0);
        step();

        // abort after first accept; start while busy is ignored
        lsm_list = 16'h00F0; lsm_ready = 1'b1; lsm_start = 1'b1;
        step();
        lsm_list = 16'h0001;
        @(negedge clk);
        chk("abt_reg0", 64'(lsm_reg), 64'd4);
        step();
        lsm_start = 1'b0; lsm_abort = 1'b1;
        @(negedge clk);
        chk("abt_reg1", 64'(lsm_reg), 64'd5);
        step();
        lsm_abort = 1'b0; lsm_ready = 1'b0;
        @(negedge clk);
        chk("abt_busy", 64'(lsm_busy), 64'h0);
        chk("abt_done", 64'(lsm_done), 64'h0);
        chk("abt_count", 64'(lsm_count), 64'd1);
        step();

        // full list, then reset mid-run
        lsm_list = 16'hFFFF; lsm_ready = 1'b1; lsm_start = 1'b1;
        step();
        lsm_start = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rrun_busy", 64'(lsm_busy), 64'h0);
        chk("rrun_count", 64'(lsm_count), 64'h0);
        chk("rrun_pc", 64'(pc), 64'h0);

        // full list runs to count 16
        lsm_start = 1'b1;
        step();
        lsm_start = 1'b0;
        for (int k = 0; k < 16; k++) step();
        @(negedge clk);
        chk("full_done", 64'(lsm_done), 64'h1);
        chk("full_count", 64'(lsm_count), 64'd16);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
